// File: rtl/lf_ssp_sample_tx_if.sv
// lf_ssp_sample_tx_if: sample input and SSP output bundle of the LF sample transmitter
interface lf_ssp_sample_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    logic enable;
    logic [7:0] sample;
    logic sample_valid;
    logic ssp_clk;
    logic ssp_frame;
    logic ssp_din;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic overflow;
    modport master (
        output enable, sample, sample_valid,
        input ssp_clk, ssp_frame, ssp_din, fifo_level, overflow
    );
    modport slave (
        input enable, sample, sample_valid,
        output ssp_clk, ssp_frame, ssp_din, fifo_level, overflow
    );
endinterface

// File: rtl/lf_ssp_sample_tx.sv
// lf_ssp_sample_tx: FIFO-buffered serializer of LF ADC samples onto the SSP pins
// Macro LF_SSP_TX_OVF_FLAG_EN prepends an "overflow since previous word" flag bit to each word.
module lf_ssp_sample_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV = 2
) (
    input logic pck0,
    input logic rst,
    lf_ssp_sample_tx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLK_DIV + 1);
`ifdef LF_SSP_TX_OVF_FLAG_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI} state_t;
    state_t state, state_n;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [LW-1:0] level;
    logic [NB-1:0] sh, sh_n;
    logic [3:0] bc, bc_n;
    logic [CW-1:0] hc, hc_n;
    logic clk_r, clk_n, frame_r, frame_n, din_r, din_n, ovf;
    logic full, pop, push, drop, half_done;
`ifdef LF_SSP_TX_OVF_FLAG_EN
    logic flag, flag_n;
    // a drop coinciding with the LOAD capture lands in the next word
    assign flag_n = drop || (flag && !pop);
`endif

    assign full = level == LW'(FIFO_DEPTH);
    assign pop = state == LOAD;
    assign push = bus.sample_valid && bus.enable && (!full || pop);
    assign drop = bus.sample_valid && bus.enable && full && !pop;
    assign half_done = hc == CW'(CLK_DIV - 1);
    assign bus.ssp_clk = clk_r;
    assign bus.ssp_frame = frame_r;
    assign bus.ssp_din = din_r;
    assign bus.fifo_level = level;
    assign bus.overflow = ovf;

    always_comb begin
        state_n = state;
        sh_n = sh;
        bc_n = bc;
        hc_n = hc;
        clk_n = clk_r;
        frame_n = frame_r;
        din_n = din_r;
        case (state)
            IDLE: begin
                {clk_n, frame_n, din_n} = 3'b000;
                state_n = level != '0 ? LOAD : IDLE;
            end
            LOAD: begin
`ifdef LF_SSP_TX_OVF_FLAG_EN
                sh_n = {flag, mem[rp]};
`else
                sh_n = mem[rp];
`endif
                bc_n = 4'(NB - 1);
                hc_n = '0;
                {clk_n, frame_n} = 2'b01;
                din_n = sh_n[NB-1];
                state_n = SHIFT_LO;
            end
            SHIFT_LO: begin
                hc_n = half_done ? '0 : hc + 1'b1;
                clk_n = half_done;
                state_n = half_done ? SHIFT_HI : SHIFT_LO;
            end
            SHIFT_HI: begin
                hc_n = half_done ? '0 : hc + 1'b1;
                if (half_done && bc != '0) begin
                    sh_n = sh << 1;
                    bc_n = bc - 1'b1;
                    {clk_n, frame_n} = 2'b00;
                    din_n = sh_n[NB-1];
                    state_n = SHIFT_LO;
                end else if (half_done) begin
                    {clk_n, frame_n, din_n} = 3'b000;
                    state_n = level != '0 ? LOAD : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // enable low behaves like reset: flush, abort the word, clear overflow
    always_ff @(posedge pck0) begin
        if (rst || !bus.enable) begin
            state <= IDLE;
            wp <= '0;
            rp <= '0;
            level <= '0;
            sh <= '0;
            bc <= '0;
            hc <= '0;
            clk_r <= 1'b0;
            frame_r <= 1'b0;
            din_r <= 1'b0;
            ovf <= 1'b0;
`ifdef LF_SSP_TX_OVF_FLAG_EN
            flag <= 1'b0;
`endif
        end else begin
            state <= state_n;
            wp <= wp + AW'(push);
            rp <= rp + AW'(pop);
            level <= level + LW'(push) - LW'(pop);
            sh <= sh_n;
            bc <= bc_n;
            hc <= hc_n;
            clk_r <= clk_n;
            frame_r <= frame_n;
            din_r <= din_n;
            ovf <= ovf | drop;
`ifdef LF_SSP_TX_OVF_FLAG_EN
            flag <= flag_n;
`endif
        end
    end

    always_ff @(posedge pck0) begin
        if (push) mem[wp] <= bus.sample;
    end
endmodule

// File: tb/tb_lf_ssp_sample_tx.sv
// tb_lf_ssp_sample_tx: directed and random stimulus checked every cycle against a timeline model
module tb_lf_ssp_sample_tx;
    localparam int DEPTH = 4;
    localparam int D = 2;
`ifdef LF_SSP_TX_OVF_FLAG_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int WORD = 2 * NB * D;
    logic pck0 = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    lf_ssp_sample_tx_if #(.FIFO_DEPTH(DEPTH)) bus();
    lf_ssp_sample_tx #(.FIFO_DEPTH(DEPTH), .CLK_DIV(D)) dut (.pck0(pck0), .rst(rst), .bus(bus));
    always #5 pck0 = ~pck0;

    // model: word start edge, next pop edge, edge at which the transmitter is free again
    int cyc = 0;
    int ws = -1;
    int pend = -1;
    int free = 0;
    int o;
    logic [NB-1:0] cw = '0;
    logic [7:0] q[$];
    logic mflag = 1'b0;
    logic movf = 1'b0;
    logic inw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h at edge %0d", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge pck0) begin
        cyc++;
        if (rst || !bus.enable) begin
            q.delete();
            ws = -1;
            pend = -1;
            free = 0;
            mflag = 1'b0;
            movf = 1'b0;
        end else begin
            if (pend == cyc) begin
                cw = NB'({mflag, q.pop_front()});
                mflag = 1'b0;
                ws = cyc;
                free = cyc + WORD;
                pend = -1;
            end else if (pend < 0 && cyc >= free && q.size() > 0) begin
                pend = cyc + 1;
            end
            if (bus.sample_valid) begin
                if (q.size() < DEPTH) q.push_back(bus.sample);
                else begin
                    movf = 1'b1;
                    mflag = 1'b1;
                end
            end
        end
        #1;
        o = cyc - ws;
        inw = ws >= 0 && o >= 0 && o < WORD;
        chk("ssp_clk", bus.ssp_clk, inw && ((o / D) % 2 == 1));
        chk("ssp_frame", bus.ssp_frame, inw && o < 2 * D);
        chk("ssp_din", bus.ssp_din, inw ? cw[NB-1-o/(2*D)] : 1'b0);
        chk("fifo_level", bus.fifo_level, q.size());
        chk("overflow", bus.overflow, movf);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge pck0);
    endtask

    task automatic push(input logic [7:0] v);
        bus.sample = v;
        bus.sample_valid = 1'b1;
        @(negedge pck0);
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_mid_word(input string tag);
        int n = 0;
        while (!(ws >= 0 && cyc - ws == 6 * D) && n < 200) begin
            @(negedge pck0);
            n++;
        end
        tests++;
        assert (n < 200) else begin
            fails++;
            $error("FAIL %s: timed out after %0d cycles, want under 200", tag, n);
        end
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.sample = '0;
        bus.sample_valid = 1'b0;
        tick(3);
        rst = 1'b0;
        bus.enable = 1'b1;
        tick(2);
        push(8'hA5);
        tick(WORD + 10);
        push(8'h01);
        push(8'h80);
        push(8'hFF);
        tick(3 * (WORD + 1) + 10);
        for (int i = 0; i < 6; i++) push(8'($urandom));
        tick(6 * (WORD + 1) + 10);
        for (int i = 0; i < 5; i++) push(8'($urandom));
        begin
            int n = 0;
            while (pend != cyc + 1 && n < 200) begin
                @(negedge pck0);
                n++;
            end
            tests++;
            assert (n < 200) else begin
                fails++;
                $error("FAIL full_pop_wait: timed out after %0d cycles, want under 200", n);
            end
        end
        push(8'hC3);
        tick(5 * (WORD + 1) + 10);
        push(8'h96);
        wait_mid_word("rst_mid_word");
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        push(8'h3C);
        tick(WORD + 10);
        push(8'h69);
        wait_mid_word("enable_mid_word");
        bus.enable = 1'b0;
        tick(1);
        bus.enable = 1'b1;
        tick(1);
        push(8'h3C);
        tick(WORD + 10);
        push(8'h00);
        push(8'h00);
        push(8'h00);
        push(8'h00);
        push(8'h00);
        push(8'h00);
        tick(2 * WORD);
        push(8'h55);
        tick(6 * (WORD + 1) + 10);
        for (int i = 0; i < 600; i++) begin
            bus.sample = 8'($urandom);
            bus.sample_valid = ($urandom % 20) == 0;
            bus.enable = ($urandom % 150) != 0;
            tick(1);
        end
        bus.enable = 1'b1;
        bus.sample_valid = 1'b0;
        tick((DEPTH + 1) * (WORD + 1) + 10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
